// File: rtl/ram_verilog_if.sv
// Instruction/data bus of the single-port opcode-driven RAM.
// The master issues an opcode, an address operand and write data each cycle.
// The slave returns the registered read result.
interface ram_verilog_if #(
  parameter int DATA_W = 16
);
  logic [15:0]       opcode;
  logic [15:0]       operand;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  modport master (
    output opcode,
    output operand,
    output write_data,
    input  read_data
  );

  modport slave (
    input  opcode,
    input  operand,
    input  write_data,
    output read_data
  );
endinterface

// File: rtl/ram_verilog.sv
// Opcode-driven single-port RAM of 2**ADDR_W words.
// opcode[15:8] selects write, read or no-op, and operand[ADDR_W-1:0] is the word address.
// The read result is registered with one cycle of latency and holds between reads.
// A synchronous reset clears the read register and every memory word.
module ram_verilog #(
  parameter int         DATA_W   = 16,
  parameter int         ADDR_W   = 8,
  parameter logic [7:0] OP_WRITE = 8'h41,
  parameter logic [7:0] OP_READ  = 8'h42
) (
  input  logic         clk,
  input  logic         reset,
  ram_verilog_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr_p0;
  logic              wr_p0;
  logic              rd_p0;
  logic [DATA_W-1:0] read_data_p1;

  // The opcode low byte and the operand upper bits are don't-care.
  // They are folded here so that they are visibly consumed.
  logic unused_bits;
  assign unused_bits = ^{bus.opcode[7:0], bus.operand[15:ADDR_W]};

  // Decode the opcode and address.
  // An opcode byte that is not an exact match, including X or Z, leaves both strobes low.
  always_comb begin
    addr_p0 = bus.operand[ADDR_W-1:0];
    wr_p0   = 1'b0;
    rd_p0   = 1'b0;
    if (bus.opcode[15:8] == OP_WRITE) wr_p0 = 1'b1;
    if (bus.opcode[15:8] == OP_READ)  rd_p0 = 1'b1;
  end

  // Memory array: reset clears every word, then writes land at the addressed word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_p0) begin
      mem[addr_p0] <= bus.write_data;
    end
  end

  // ---- stage p0 -> p1: registered read port, which holds its value between reads ----
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_p1 <= '0;
    end else if (rd_p0) begin
      read_data_p1 <= mem[addr_p0];
    end
  end

  assign bus.read_data = read_data_p1;
endmodule

// File: tb/tb_ram_verilog.sv
// Directed bench for ram_verilog.
// Each vector is one clocked operation followed by a check of read_data.
module tb_ram_verilog;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  ram_verilog_if #(.DATA_W(16)) bus ();

  ram_verilog #(
    .DATA_W  (16),
    .ADDR_W  (8),
    .OP_WRITE(8'h41),
    .OP_READ (8'h42)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present one operation for one rising edge, then settle just after that edge.
  task automatic op(input logic rst_v, input logic [15:0] opc,
                    input logic [15:0] opr, input logic [15:0] wd);
    @(negedge clk);
    reset          = rst_v;
    bus.opcode     = opc;
    bus.operand    = opr;
    bus.write_data = wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    bus.opcode     = 16'h0000;
    bus.operand    = 16'h0000;
    bus.write_data = 16'h0000;

    op(1'b1, 16'h0000, 16'h0000, 16'h0000);
    op(1'b1, 16'h0000, 16'h0000, 16'h0000);
    chk("reset_rd", bus.read_data, 16'h0000);

    op(1'b0, 16'h4200, 16'h0005, 16'h0000);
    chk("rd_05_after_reset", bus.read_data, 16'h0000);

    op(1'b0, 16'h4100, 16'h0001, 16'h000A);
    chk("wr_01_rd_hold", bus.read_data, 16'h0000);
    op(1'b0, 16'h4200, 16'h0001, 16'h0000);
    chk("rd_01", bus.read_data, 16'h000A);

    op(1'b0, 16'h4100, 16'h0002, 16'h0010);
    chk("wr_02_rd_hold", bus.read_data, 16'h000A);
    op(1'b0, 16'h4200, 16'h0002, 16'h0000);
    chk("rd_02", bus.read_data, 16'h0010);
    op(1'b0, 16'h4200, 16'h0001, 16'h0000);
    chk("rd_01_again", bus.read_data, 16'h000A);

    // Non-matching opcodes must leave the memory and read_data untouched.
    op(1'b0, 16'h0000, 16'h0001, 16'hDEAD);
    chk("nop_0000", bus.read_data, 16'h000A);
    op(1'b0, 16'h4300, 16'h0002, 16'hBEEF);
    chk("nop_4300", bus.read_data, 16'h000A);
    op(1'b0, 16'h4200, 16'h0002, 16'h0000);
    chk("rd_02_after_nop", bus.read_data, 16'h0010);
    op(1'b0, 16'h42FF, 16'h0001, 16'h0000);
    chk("rd_01_low_byte_ignored", bus.read_data, 16'h000A);

    // Upper operand bits are ignored, so operand 0xFF01 addresses word 0x01.
    op(1'b0, 16'h41AB, 16'hFF01, 16'h1234);
    chk("wr_ff01_rd_hold", bus.read_data, 16'h000A);
    op(1'b0, 16'h4200, 16'h0001, 16'h0000);
    chk("rd_01_aliased", bus.read_data, 16'h1234);
    op(1'b0, 16'h4200, 16'h0002, 16'h0000);
    chk("rd_02_no_corrupt", bus.read_data, 16'h0010);

    // Back-to-back write then read of a fresh address.
    op(1'b0, 16'h4100, 16'h0003, 16'h7777);
    op(1'b0, 16'h4200, 16'h0003, 16'h0000);
    chk("rd_03_b2b", bus.read_data, 16'h7777);

    // Reset discards a concurrent write and clears the memory.
    op(1'b0, 16'h4100, 16'h00FF, 16'hBEEF);
    op(1'b0, 16'h4200, 16'h00FF, 16'h0000);
    chk("rd_ff", bus.read_data, 16'hBEEF);
    op(1'b1, 16'h4100, 16'h00FF, 16'h5555);
    chk("reset_with_wr", bus.read_data, 16'h0000);
    op(1'b0, 16'h4200, 16'h00FF, 16'h0000);
    chk("rd_ff_after_reset", bus.read_data, 16'h0000);
    op(1'b0, 16'h4200, 16'h0001, 16'h0000);
    chk("rd_01_after_reset", bus.read_data, 16'h0000);

    // A read presented during reset is discarded, and read_data stays 0.
    op(1'b0, 16'h4100, 16'h0004, 16'hA5A5);
    op(1'b1, 16'h4200, 16'h0004, 16'h0000);
    chk("reset_with_rd", bus.read_data, 16'h0000);
    op(1'b0, 16'h4200, 16'h0004, 16'h0000);
    chk("rd_04_cleared", bus.read_data, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_verilog.md
RAM_VERILOG -- requirements
Module: ram_verilog

Interface
REQ-001 Parameter DATA_W, default 16: width of data words, write_data and read_data.
REQ-002 Parameter ADDR_W, default 8: address width; memory depth SHALL be 2**ADDR_W words (256 by default).
REQ-003 Parameter OP_WRITE, default 8'h41: opcode[15:8] value selecting a write.
REQ-004 Parameter OP_READ, default 8'h42: opcode[15:8] value selecting a read.
REQ-005 clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 opcode  input  16  instruction word; only [15:8] decoded, [7:0] ignored.
REQ-008 operand  input  16  address source; operand[ADDR_W-1:0] is the word address, upper bits ignored.
REQ-009 write_data  input  DATA_W  data stored on a write.
REQ-010 read_data  output  DATA_W  registered read result.

Function
REQ-011 The block SHALL hold 2**ADDR_W words of DATA_W bits, addressed by operand[ADDR_W-1:0].
REQ-012 Write: when reset=0 and opcode[15:8]==OP_WRITE at a rising edge, mem[addr] SHALL take write_data at that edge.
REQ-013 Write SHALL leave read_data unchanged.
REQ-014 Read: when reset=0 and opcode[15:8]==OP_READ at a rising edge, read_data SHALL take mem[addr] at that edge (latency 1 cycle, registered output).
REQ-015 A read SHALL return the value written by any write completed at an earlier edge, including the immediately preceding cycle.
REQ-016 Any other opcode[15:8] value, including X or Z, SHALL be a no-op: memory and read_data hold.
REQ-017 read_data SHALL hold its last value indefinitely between reads.
REQ-018 Addresses SHALL be decoded modulo 2**ADDR_W; no out-of-range condition exists.
REQ-019 No handshake, valid, or busy signal exists; one operation SHALL be accepted per cycle, back-to-back, with no stall.

Reset
REQ-020 On a rising edge with reset=1, read_data SHALL become 0.
REQ-021 On a rising edge with reset=1, all memory words SHALL become 0.
REQ-022 Reset SHALL take priority over any opcode in the same cycle; a write or read presented during reset SHALL be discarded.
REQ-023 Reset asserted between a write and a later read SHALL cause that read to return 0.
REQ-024 The first operation after reset deasserts SHALL be honoured at the first rising edge with reset=0.

Verification
REQ-025 Reset for 2 cycles, then read addr 0x05 -> read_data=0x0000 both after reset and after the read.
REQ-026 Write 0x000A to addr 0x01; next cycle read addr 0x01 -> read_data=0x000A one edge after the read; during the write cycle read_data unchanged.
REQ-027 Write 0x0010 to addr 0x02, read 0x02, then read 0x01 -> read_data=0x0010, then 0x000A; no cross-address corruption.
REQ-028 Opcode 0x0000 and 0x4300 with any operand or write_data -> memory and read_data unchanged; subsequent read of 0x01 still 0x000A.
REQ-029 Operand 0xFF01 with write 0x1234 -> stored at addr 0x01; read with operand 0x0001 returns 0x1234.
REQ-030 Write 0xBEEF to addr 0xFF, assert reset with OP_WRITE 0x5555 to addr 0xFF presented, release, read 0xFF -> read_data=0x0000.
